// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one registered unsigned A > B comparator.
// Each operation runs IDLE -> CMP -> RESP, with a one-cycle done pulse in RESP.
module cmp_arbiter #(
  parameter int N = 4,
  parameter int W = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic           result,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          cmp_q, cmp_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  done_q, done_d;
  logic          result_q, result_d;
  logic          busy_q, busy_d;

  logic [PW-1:0] sel;
  logic          found;

  // First set request bit searching upward from ptr, wrapping at N.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr_q) + i) % N]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr_q) + i) % N);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    cmp_d    = cmp_q;
    grant_d  = grant_q;
    done_d   = done_q;
    result_d = result_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = a_in[sel*W +: W];
          b_d     = b_in[sel*W +: W];
          idx_d   = sel;
          grant_d = ONE << sel;
          busy_d  = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        cmp_d    = (a_q > b_q);
        result_d = (a_q > b_q);
        done_d   = grant_q;
        state_d  = RESP;
      end
      RESP: begin
        grant_d = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        ptr_d   = (idx_q == PW'(N-1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cmp_q    <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cmp_q    <= cmp_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: a round-robin reference model pushes
// expected results at grant; a negedge monitor pops them on done.
module tb_cmp_arbiter;

  localparam int N = 4;
  localparam int W = 10;
  localparam logic [N-1:0] ONE = 4'b0001;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           result;
  logic           busy;

  cmp_arbiter #(.N(N), .W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .grant  (grant),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;
    bit res;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_phase = 0;
  int   m_k = 0;
  int   m_ptr = 0;
  int   cyc = 0;
  int   last_done = -1;
  bit   spacing_on = 1'b0;

  // Reference: one operation occupies three cycles; winner is the first
  // requester at or after the pointer, pointer moves past the winner.
  always @(posedge clk or posedge reset) begin : model
    logic [W-1:0] ma, mb;
    int c;
    if (reset) begin
      m_phase = 0;
      m_ptr   = 0;
      sb.delete();
    end else if (m_phase == 2) begin
      m_phase = 0;
      m_ptr   = (m_k + 1) % N;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (req != '0) begin
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (req[c]) begin
          m_k = c;
          break;
        end
      end
      ma = a_in[m_k*W +: W];
      mb = b_in[m_k*W +: W];
      sb.push_back('{k: m_k, res: (int'(ma) > int'(mb))});
      m_phase = 1;
    end
  end

  always @(negedge clk) begin : monitor
    logic [N-1:0] eg;
    exp_t e;
    cyc++;
    eg = (m_phase != 0) ? (ONE << m_k) : '0;
    checks++;
    if (grant !== eg || busy !== (m_phase != 0)) begin
      errors++;
      $display("FAIL grant/busy cyc=%0d: got %b/%b expected %b/%b",
               cyc, grant, busy, eg, (m_phase != 0));
    end
    if (done != '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d: got %b expected none", cyc, done);
      end else begin
        e = sb.pop_front();
        if (done !== (ONE << e.k) || result !== e.res) begin
          errors++;
          $display("FAIL done/result cyc=%0d: got %b/%b expected %b/%b",
                   cyc, done, result, ONE << e.k, e.res);
        end
      end
      if (spacing_on && last_done >= 0) begin
        checks++;
        if (cyc - last_done != 3) begin
          errors++;
          $display("FAIL done_spacing: got %0d expected 3", cyc - last_done);
        end
      end
      last_done = cyc;
    end else if (m_phase == 2) begin
      checks++;
      errors++;
      $display("FAIL missing_done cyc=%0d: got 0 expected %b", cyc, ONE << m_k);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    a_in[k*W +: W] = a;
    b_in[k*W +: W] = b;
  endtask

  task automatic single(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    set_ops(0, a, b);
    req = 4'b0001;
    @(posedge clk); #1;
    chk("single_grant", grant, 4'b0001);
    chk("single_busy", busy, 1);
    req = '0;
    @(posedge clk); #1;
    chk("single_done", done, 4'b0001);
    chk("single_result", result, (int'(a) > int'(b)) ? 1 : 0);
    @(posedge clk); #1;
    chk("single_idle_busy", busy, 0);
    chk("single_idle_grant", grant, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;

    single(10'd91, 10'd102);
    single(10'd102, 10'd91);
    single(10'd512, 10'd512);
    single(10'd1023, 10'd0);

    // All four requesting continuously from reset.
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < N; k++) set_ops(k, 10'($urandom), 10'($urandom));
    req = 4'b1111;
    last_done  = -1;
    spacing_on = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      chk("rr_grant", grant, ONE << (j % N));
      for (int k = 0; k < N; k++) set_ops(k, 10'($urandom), 10'($urandom));
      @(posedge clk);
      @(posedge clk);
    end
    req = '0;
    repeat (4) @(posedge clk);
    spacing_on = 1'b0;

    // Fairness: serve requester 1, then 0 and 1 together.
    do_reset();
    set_ops(1, 10'd7, 10'd3);
    req = 4'b0010;
    @(posedge clk); #1;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_ops(0, 10'd1, 10'd2);
    req = 4'b0011;
    @(posedge clk); #1;
    chk("fair_first", grant, 4'b0001);
    repeat (3) @(posedge clk); #1;
    chk("fair_second", grant, 4'b0010);
    req = '0;
    repeat (3) @(posedge clk);

    // Operands and req change after grant.
    @(negedge clk);
    set_ops(0, 10'd300, 10'd200);
    req = 4'b0001;
    @(posedge clk); #1;
    set_ops(0, 10'd0, 10'd1023);
    req = '0;
    @(posedge clk); #1;
    chk("latched_done", done, 4'b0001);
    chk("latched_result", result, 1);
    repeat (2) @(posedge clk);

    // Reset during CMP aborts without a done.
    @(negedge clk);
    set_ops(0, 10'd5, 10'd3);
    req = 4'b0001;
    @(posedge clk); #1;
    req = '0;
    #2;
    reset = 1'b1;
    #1;
    chk("abort_grant", grant, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_ops(2, 10'd600, 10'd599);
    req = 4'b0100;
    @(posedge clk); #1;
    chk("post_rst_grant", grant, 4'b0100);
    req = '0;
    @(posedge clk); #1;
    chk("post_rst_done", done, 4'b0100);
    repeat (2) @(posedge clk);

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      req  = 4'($urandom);
      a_in = {$urandom, $urandom};
      b_in = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b_in = a_in;
    end
    @(negedge clk);
    req = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
